branch_redirect_ctrl: RTL and testbench
=======================================

# branch_redirect_ctrl

Sequencer that sits between the EX-stage branch/jump resolution logic and the fetch/pipeline-register control of the RISC-V core. It samples the taken-branch select and target each cycle, drives a registered PC redirect into fetch, and holds IF/ID and ID/EX flush for a fixed number of cycles so wrong-path instructions are squashed. While a redirect is in flight, further branch decisions from EX come from wrong-path instructions and are ignored.

## Interface
Parameters:
- PC_W, 9, width of the instruction-memory PC.
- FLUSH_CYCLES, 2, cycles of flush per redirect; legal range 1..4.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- ex_valid  in  1  EX stage holds a valid (non-bubble) instruction.
- pc_sel  in  1  branch taken / jump, from branch resolution.
- br_pc  in  32  branch/jump target for the EX instruction.
- stall_in  in  1  pipeline stall request from the hazard unit.
- pc_redirect  out  1  fetch loads redirect_pc this cycle.
- redirect_pc  out  PC_W  registered target, bits [1:0] forced to 0.
- flush_ifid  out  1  clear IF/ID register.
- flush_idex  out  1  clear ID/EX register.
- busy  out  1  controller not in IDLE.
- misalign  out  1  one-cycle pulse with pc_redirect when br_pc[1:0] != 0.

## Operation
- States: IDLE, REDIRECT, FLUSH. Also holds a 2-bit flush counter and the redirect_pc register.
- IDLE: if ex_valid && pc_sel at a rising edge, the controller accepts the branch. It latches br_pc[PC_W-1:2] into redirect_pc, forces redirect_pc[1:0] = 0, latches misalign = |br_pc[1:0]|, and goes to REDIRECT. stall_in does not block acceptance.
- REDIRECT outputs: pc_redirect = 1, flush_ifid = 1, flush_idex = 1, busy = 1.
- REDIRECT transitions:
  - stall_in = 1: stay in REDIRECT with outputs held, so the redirect is never lost.
  - Otherwise, FLUSH_CYCLES == 1: go to IDLE.
  - Otherwise: go to FLUSH with counter = FLUSH_CYCLES-1.
- FLUSH outputs: flush_ifid = 1, flush_idex = 1, pc_redirect = 0, busy = 1.
- FLUSH counter: decrements each cycle stall_in = 0 and freezes when stall_in = 1. When it reaches 1 and decrements, go to IDLE.
- In REDIRECT and FLUSH, pc_sel, br_pc and ex_valid are ignored, including on the last FLUSH cycle.
- redirect_pc holds its value until the next acceptance.
- Width rule: targets are truncated to the low PC_W bits with no error. Only bits [1:0] are checked.

## Timing
- Reset values: state IDLE, counter 0, redirect_pc 0. All outputs are 0.
- Reset is asynchronous and overrides any state. A redirect in flight is dropped and no output stays asserted after reset.
- Branch accepted at edge T, no stalls:
  - Cycle T+1: pc_redirect = 1.
  - Cycles T+1..T+FLUSH_CYCLES: flush_ifid and flush_idex high.
  - Cycle T+FLUSH_CYCLES+1: IDLE. pc_sel is sampled again at the end of this cycle.
- All outputs are registered or decoded from state only, with no combinational path from inputs.
- Each stall cycle extends the REDIRECT or FLUSH state by exactly one cycle.

## Configuration
- BRANCH_STATS_EN defined: adds two outputs.
  - redirect_cnt (out, 32): increments on each accepted branch.
  - shadow_cnt (out, 32): increments each cycle ex_valid && pc_sel is seen while busy.
  - Both reset to 0 and wrap modulo 2^32.
- BRANCH_STATS_EN undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset, then ex_valid=1, pc_sel=1, br_pc=0x0000_0040, FLUSH_CYCLES=2:
  - Next cycle: pc_redirect=1, redirect_pc=0x040, both flushes high.
  - Following cycle: flushes only.
  - Then IDLE, busy=0.
- Back-to-back: pc_sel=1 held for 4 cycles with targets 0x10, 0x20, 0x30, 0x40.
  - Only 0x10 is redirected.
  - The fourth cycle (IDLE again) accepts 0x40.
  - With stats on: shadow_cnt=2, redirect_cnt=2.
- stall_in=1 for 3 cycles starting in REDIRECT: pc_redirect stays high 4 cycles total, then FLUSH for 1 cycle, then IDLE.
- br_pc=0x0000_0206, PC_W=9: redirect_pc=0x004 and misalign pulses for exactly 1 cycle.
- reset asserted mid-FLUSH: all outputs go to 0 immediately. A subsequent pc_sel=1 is accepted on the first edge after deassertion.
- FLUSH_CYCLES=1: a taken branch produces exactly one cycle of pc_redirect plus flushes, then IDLE.

Source files
------------

// File: rtl/branch_redirect_ctrl_if.sv
// Handshake bundle between EX-stage branch resolution and the redirect controller.
// Optional statistics outputs appear only when BRANCH_STATS_EN is defined.
interface branch_redirect_ctrl_if #(
  parameter int PC_W = 9
);
  logic            ex_valid;
  logic            pc_sel;
  logic [31:0]     br_pc;
  logic            stall_in;
  logic            pc_redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            flush_ifid;
  logic            flush_idex;
  logic            busy;
  logic            misalign;
`ifdef BRANCH_STATS_EN
  logic [31:0]     redirect_cnt;
  logic [31:0]     shadow_cnt;
`endif

  // master: EX/hazard side driving decisions; slave: the redirect controller
`ifdef BRANCH_STATS_EN
  modport master (
    output ex_valid, pc_sel, br_pc, stall_in,
    input  pc_redirect, redirect_pc, flush_ifid, flush_idex, busy, misalign,
           redirect_cnt, shadow_cnt
  );
  modport slave (
    input  ex_valid, pc_sel, br_pc, stall_in,
    output pc_redirect, redirect_pc, flush_ifid, flush_idex, busy, misalign,
           redirect_cnt, shadow_cnt
  );
`else
  modport master (
    output ex_valid, pc_sel, br_pc, stall_in,
    input  pc_redirect, redirect_pc, flush_ifid, flush_idex, busy, misalign
  );
  modport slave (
    input  ex_valid, pc_sel, br_pc, stall_in,
    output pc_redirect, redirect_pc, flush_ifid, flush_idex, busy, misalign
  );
`endif
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect sequencer: registers a taken-branch target for fetch and holds
// IF/ID + ID/EX flush for FLUSH_CYCLES. Define BRANCH_STATS_EN for redirect/shadow counters.
module branch_redirect_ctrl #(
  parameter int PC_W         = 9,
  parameter int FLUSH_CYCLES = 2
) (
  input logic                  clk,
  input logic                  reset,
  branch_redirect_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES - 1);

  state_t          r_state, w_nextState;
  logic [1:0]      r_cnt, w_nextCnt;
  logic [PC_W-1:0] r_pc, w_nextPc;
  logic            r_mis, w_nextMis;
  logic            w_accept;
  logic            w_pcRedirect, w_flush, w_busy, w_misalign;
  logic            w_unusedBrPc;

  // Upper target bits are deliberately truncated away
  assign w_unusedBrPc = ^bus.br_pc[31:PC_W];
  assign w_accept     = (r_state == IDLE) && bus.ex_valid && bus.pc_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
      r_pc    <= '0;
      r_mis   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      r_pc    <= w_nextPc;
      r_mis   <= w_nextMis;
    end
  end

  // Branch decisions are only honoured in IDLE; anything seen while busy is wrong-path
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextPc    = r_pc;
    w_nextMis   = r_mis;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextState = REDIRECT;
          w_nextPc    = {bus.br_pc[PC_W-1:2], 2'b00};
          w_nextMis   = |bus.br_pc[1:0];
        end
      end
      REDIRECT: begin
        if (!bus.stall_in) begin
          if (FLUSH_CYCLES == 1) begin
            w_nextState = IDLE;
          end else begin
            w_nextState = FLUSH;
            w_nextCnt   = CNT_INIT;
          end
        end
      end
      FLUSH: begin
        if (!bus.stall_in) begin
          w_nextCnt = r_cnt - 2'd1;
          if (r_cnt <= 2'd1) begin
            w_nextState = IDLE;
          end
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_comb begin
    w_pcRedirect = 1'b0;
    w_flush      = 1'b0;
    w_busy       = 1'b0;
    w_misalign   = 1'b0;
    case (r_state)
      REDIRECT: begin
        w_pcRedirect = 1'b1;
        w_flush      = 1'b1;
        w_busy       = 1'b1;
        w_misalign   = r_mis;
      end
      FLUSH: begin
        w_flush = 1'b1;
        w_busy  = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  assign bus.pc_redirect = w_pcRedirect;
  assign bus.redirect_pc = r_pc;
  assign bus.flush_ifid  = w_flush;
  assign bus.flush_idex  = w_flush;
  assign bus.busy        = w_busy;
  assign bus.misalign    = w_misalign;

`ifdef BRANCH_STATS_EN
  logic [31:0] r_redirectCnt;
  logic [31:0] r_shadowCnt;

  // Shadow count tracks taken decisions squashed while a redirect is in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_redirectCnt <= 32'd0;
      r_shadowCnt   <= 32'd0;
    end else begin
      if (w_accept) begin
        r_redirectCnt <= r_redirectCnt + 32'd1;
      end
      if ((r_state != IDLE) && bus.ex_valid && bus.pc_sel) begin
        r_shadowCnt <= r_shadowCnt + 32'd1;
      end
    end
  end

  assign bus.redirect_cnt = r_redirectCnt;
  assign bus.shadow_cnt   = r_shadowCnt;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: directed vectors push expected outputs,
// a monitor pops and compares one cycle later. Main DUT uses FLUSH_CYCLES=2, second uses 1.
module tb_branch_redirect_ctrl;

  typedef struct {
    string       name;
    logic [13:0] vec;
  } exp_t;

  logic clk;
  logic reset;

  exp_t q0[$];
  exp_t q1[$];
  int   nChecks = 0;
  int   nPass   = 0;

  branch_redirect_ctrl_if #(.PC_W(9)) bus0 ();
  branch_redirect_ctrl_if #(.PC_W(9)) bus1 ();

  branch_redirect_ctrl #(.PC_W(9), .FLUSH_CYCLES(2)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  branch_redirect_ctrl #(.PC_W(9), .FLUSH_CYCLES(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Vector layout: {pc_redirect, redirect_pc[8:0], flush_ifid, flush_idex, busy, misalign}
  function automatic logic [13:0] mk(input logic r, input logic [8:0] p,
                                     input logic f, input logic b, input logic m);
    return {r, p, f, f, b, m};
  endfunction

  function automatic logic [13:0] act0();
    return {bus0.pc_redirect, bus0.redirect_pc, bus0.flush_ifid, bus0.flush_idex,
            bus0.busy, bus0.misalign};
  endfunction

  function automatic logic [13:0] act1();
    return {bus1.pc_redirect, bus1.redirect_pc, bus1.flush_ifid, bus1.flush_idex,
            bus1.busy, bus1.misalign};
  endfunction

  task automatic checkOutput(input string name, input logic [13:0] got, input logic [13:0] want);
    nChecks++;
    if (got === want) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got redir=%b pc=0x%03h fi=%b fx=%b busy=%b mis=%b, expected redir=%b pc=0x%03h fi=%b fx=%b busy=%b mis=%b",
               name, got[13], got[12:4], got[3], got[2], got[1], got[0],
               want[13], want[12:4], want[3], want[2], want[1], want[0]);
    end
  endtask

  task automatic checkCount(input string name, input logic [31:0] got, input logic [31:0] want);
    nChecks++;
    if (got === want) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Called at a falling edge: drive inputs, queue the response expected after the next rising edge
  task automatic applyStimulus(input string name, input logic ev, input logic sel,
                               input logic [31:0] pc, input logic stall, input logic [13:0] want);
    exp_t e;
    bus0.ex_valid = ev;
    bus0.pc_sel   = sel;
    bus0.br_pc    = pc;
    bus0.stall_in = stall;
    e.name = name;
    e.vec  = want;
    q0.push_back(e);
    @(negedge clk);
  endtask

  task automatic applyStimulus1(input string name, input logic ev, input logic sel,
                                input logic [31:0] pc, input logic stall, input logic [13:0] want);
    exp_t e;
    bus1.ex_valid = ev;
    bus1.pc_sel   = sel;
    bus1.br_pc    = pc;
    bus1.stall_in = stall;
    e.name = name;
    e.vec  = want;
    q1.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        checkOutput(e.name, act0(), e.vec);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        checkOutput(e.name, act1(), e.vec);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] rc0, sc0;
`endif

  initial begin
    reset = 1'b1;
    bus0.ex_valid = 1'b0; bus0.pc_sel = 1'b0; bus0.br_pc = 32'd0; bus0.stall_in = 1'b0;
    bus1.ex_valid = 1'b0; bus1.pc_sel = 1'b0; bus1.br_pc = 32'd0; bus1.stall_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_dut0", act0(), mk(0, 9'h000, 0, 0, 0));
    checkOutput("reset_dut1", act1(), mk(0, 9'h000, 0, 0, 0));
    reset = 1'b0;

    // Basic taken branch, two flush cycles
    applyStimulus("t1_redirect", 1, 1, 32'h0000_0040, 0, mk(1, 9'h040, 1, 1, 0));
    applyStimulus("t1_flush",    0, 0, 32'h0,         0, mk(0, 9'h040, 1, 1, 0));
    applyStimulus("t1_idle",     0, 0, 32'h0,         0, mk(0, 9'h040, 0, 0, 0));

`ifdef BRANCH_STATS_EN
    rc0 = bus0.redirect_cnt;
    sc0 = bus0.shadow_cnt;
`endif
    // Back-to-back decisions: only the first and the one landing in IDLE are taken
    applyStimulus("t2_take10",   1, 1, 32'h10, 0, mk(1, 9'h010, 1, 1, 0));
    applyStimulus("t2_ign20",    1, 1, 32'h20, 0, mk(0, 9'h010, 1, 1, 0));
    applyStimulus("t2_ign30",    1, 1, 32'h30, 0, mk(0, 9'h010, 0, 0, 0));
    applyStimulus("t2_take40",   1, 1, 32'h40, 0, mk(1, 9'h040, 1, 1, 0));
    applyStimulus("t2_flush",    0, 0, 32'h0,  0, mk(0, 9'h040, 1, 1, 0));
    applyStimulus("t2_idle",     0, 0, 32'h0,  0, mk(0, 9'h040, 0, 0, 0));
`ifdef BRANCH_STATS_EN
    checkCount("t2_redirect_cnt", bus0.redirect_cnt - rc0, 32'd2);
    checkCount("t2_shadow_cnt",   bus0.shadow_cnt - sc0,   32'd2);
`endif

    // Stall held three cycles in REDIRECT
    applyStimulus("t3_redirect", 1, 1, 32'h80, 0, mk(1, 9'h080, 1, 1, 0));
    applyStimulus("t3_stall1",   1, 1, 32'h90, 1, mk(1, 9'h080, 1, 1, 0));
    applyStimulus("t3_stall2",   0, 0, 32'h0,  1, mk(1, 9'h080, 1, 1, 0));
    applyStimulus("t3_stall3",   0, 0, 32'h0,  1, mk(1, 9'h080, 1, 1, 0));
    applyStimulus("t3_flush",    0, 0, 32'h0,  0, mk(0, 9'h080, 1, 1, 0));
    applyStimulus("t3_idle",     0, 0, 32'h0,  0, mk(0, 9'h080, 0, 0, 0));

    // Stall does not block acceptance, and freezes the FLUSH counter
    applyStimulus("t3b_accept",  1, 1, 32'h100, 1, mk(1, 9'h100, 1, 1, 0));
    applyStimulus("t3b_flush",   0, 0, 32'h0,   0, mk(0, 9'h100, 1, 1, 0));
    applyStimulus("t3b_fstall",  0, 0, 32'h0,   1, mk(0, 9'h100, 1, 1, 0));
    applyStimulus("t3b_idle",    0, 0, 32'h0,   0, mk(0, 9'h100, 0, 0, 0));

    // Misaligned target with truncation above PC_W
    applyStimulus("t4_misalign", 1, 1, 32'h0000_0206, 0, mk(1, 9'h004, 1, 1, 1));
    applyStimulus("t4_flush",    0, 0, 32'h0,         0, mk(0, 9'h004, 1, 1, 0));
    applyStimulus("t4_idle",     0, 0, 32'h0,         0, mk(0, 9'h004, 0, 0, 0));

    // Reset mid-FLUSH, then accept on the first edge after release
    applyStimulus("t5_redirect", 1, 1, 32'h44, 0, mk(1, 9'h044, 1, 1, 0));
    applyStimulus("t5_flush",    0, 0, 32'h0,  0, mk(0, 9'h044, 1, 1, 0));
    reset = 1'b1;
    #1;
    checkOutput("t5_async_reset", act0(), mk(0, 9'h000, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    applyStimulus("t5_post_reset", 1, 1, 32'h48, 0, mk(1, 9'h048, 1, 1, 0));
    applyStimulus("t5_flush2",     0, 0, 32'h0,  0, mk(0, 9'h048, 1, 1, 0));
    applyStimulus("t5_idle",       0, 0, 32'h0,  0, mk(0, 9'h048, 0, 0, 0));

    // Single flush cycle variant
    applyStimulus1("t6_redirect", 1, 1, 32'h3C, 0, mk(1, 9'h03C, 1, 1, 0));
    applyStimulus1("t6_idle",     0, 0, 32'h0,  0, mk(0, 9'h03C, 0, 0, 0));
    applyStimulus1("t6_accept",   1, 1, 32'h51, 1, mk(1, 9'h050, 1, 1, 1));
    applyStimulus1("t6_stall",    1, 1, 32'h60, 1, mk(1, 9'h050, 1, 1, 1));
    applyStimulus1("t6_idle2",    0, 0, 32'h0,  0, mk(0, 9'h050, 0, 0, 0));

    repeat (3) @(negedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      nChecks++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", q0.size() + q1.size());
    end
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
